// File: rtl/sub_16_serial_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
package sub_16_pkg;

    localparam int unsigned WIDTH_DEF   = 16;
    localparam int unsigned DIGIT_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of digits per operand; width must be a multiple of digit width.
    function automatic int unsigned ndig(input int unsigned width, input int unsigned digit_w);
        return width / digit_w;
    endfunction

    // Digit counter width, kept at least one bit for single-digit configurations.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sub_16_serial_digit.sv
// Combinational DIGIT_W-bit subtractor with borrow in/out.
module sub_digit #(
    parameter int unsigned DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    input  logic               bi,
    output logic [DIGIT_W-1:0] d,
    output logic               bo
);

    // One extra bit captures the borrow as the wrapped MSB of the difference.
    always_comb begin
        {bo, d} = {1'b0, x} - {1'b0, y} - {{DIGIT_W{1'b0}}, bi};
    end

endmodule

// File: rtl/sub_16_serial.sv
// Digit-serial subtractor: result = (a - b) mod 2^WIDTH, borrow = (a < b).
// One digit per clock, LSB first, over valid/ready handshakes on both sides.
module sub_16_serial
    import sub_16_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned DIGIT_W = DIGIT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             borrow
);

    localparam int unsigned NDIG  = ndig(WIDTH, DIGIT_W);
    localparam int unsigned CNT_W = cnt_w(NDIG);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   a_q,     a_d;
    logic [WIDTH-1:0]   b_q,     b_d;
    logic               bi_q,    bi_d;
    logic [WIDTH-1:0]   res_q,   res_d;
    logic               bor_q,   bor_d;

    logic [DIGIT_W-1:0] dig_x, dig_y, dig_d;
    logic               dig_bo;

    // Select the current digit slice of the latched operands.
    always_comb begin
        dig_x = '0;
        dig_y = '0;
        for (int unsigned k = 0; k < NDIG; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                dig_x = a_q[k*DIGIT_W +: DIGIT_W];
                dig_y = b_q[k*DIGIT_W +: DIGIT_W];
            end
        end
    end

    sub_digit #(
        .DIGIT_W (DIGIT_W)
    ) u_digit (
        .x  (dig_x),
        .y  (dig_y),
        .bi (bi_q),
        .d  (dig_d),
        .bo (dig_bo)
    );

    // Next-state logic: operand capture, per-digit result write, handshake sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        bi_d    = bi_q;
        res_d   = res_q;
        bor_d   = bor_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    bi_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Result keeps its previous value outside the digit being written.
                for (int unsigned k = 0; k < NDIG; k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        res_d[k*DIGIT_W +: DIGIT_W] = dig_d;
                    end
                end
                bi_d  = dig_bo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    bor_d   = dig_bo;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously so an aborted op leaves no stale output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            bi_q    <= 1'b0;
            res_q   <= '0;
            bor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            bi_q    <= bi_d;
            res_q   <= res_d;
            bor_q   <= bor_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = res_q;
    assign borrow    = bor_q;

endmodule
